// File: rtl/scan_pkg.sv
// ============================================================================
// Module      : scan_pkg
// Description : Shared constants, types and nibble-select helper for digit_scan.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package scan_pkg;

    localparam int DIGITS = 4;
    localparam int CODE_W = 2;
    localparam int NIB_W  = 4;
    localparam int BUF_W  = DIGITS * NIB_W;

    typedef logic [CODE_W-1:0] code_t;
    typedef logic [NIB_W-1:0]  nib_t;
    typedef logic [BUF_W-1:0]  buf_t;

    localparam code_t LAST_CODE = code_t'(DIGITS - 1);

    function automatic nib_t sel_nibble(input buf_t b, input code_t c);
        return b[c*NIB_W +: NIB_W];
    endfunction

endpackage

`default_nettype wire

// File: rtl/digit_scan_tick_gen.sv
// ============================================================================
// Module      : tick_gen
// Description : Slot prescaler; counts 0..DIV-1 while enabled, ticks on DIV-1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_gen #(
    parameter int DIV   = 4,
    parameter int CNT_W = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic             tick,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_last;

    assign at_last = (cnt_q == C_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = at_last ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en & at_last;
    assign cnt  = cnt_q;

endmodule

`default_nettype wire

// File: rtl/digit_scan.sv
// ============================================================================
// Module      : digit_scan
// Description : Four-digit multiplexed display scanner with double-buffered
//               nibble data. Optional macro SCAN_BLANK_EN adds per-slot blanking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module digit_scan
    import scan_pkg::*;
#(
    parameter int DIV   = 4,
    parameter int BLANK = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              load,
    input  logic [BUF_W-1:0]  wdata,
    output logic [CODE_W-1:0] code,
    output logic [NIB_W-1:0]  digit,
    output logic              valid,
    output logic              frame
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic             tick;
    logic             wrap;
    logic [CNT_W-1:0] cnt;

    code_t code_q,    code_d;
    buf_t  active_q,  active_d;
    buf_t  pending_q, pending_d;
    logic  pend_q,    pend_d;
    logic  frame_q,   frame_d;

    tick_gen #(
        .DIV   (DIV),
        .CNT_W (CNT_W)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .tick  (tick),
        .cnt   (cnt)
    );

    assign wrap = tick & (code_q == LAST_CODE);

    // A load landing on the wrap edge bypasses the pending buffer entirely.
    always_comb begin
        code_d    = tick ? code_q + 1'b1 : code_q;
        active_d  = active_q;
        pending_d = load ? wdata : pending_q;
        pend_d    = pend_q;
        frame_d   = wrap;
        if (wrap) begin
            pend_d = 1'b0;
            if (load) begin
                active_d = wdata;
            end else if (pend_q) begin
                active_d = pending_q;
            end
        end else if (load) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q    <= '0;
            active_q  <= '0;
            pending_q <= '0;
            pend_q    <= 1'b0;
            frame_q   <= 1'b0;
        end else begin
            code_q    <= code_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            pend_q    <= pend_d;
            frame_q   <= frame_d;
        end
    end

    assign code  = code_q;
    assign digit = sel_nibble(active_q, code_q);
    assign frame = frame_q & en;

    // valid is combinational in en, so it is gated with rst_n to go dark during reset.
`ifdef SCAN_BLANK_EN
    localparam logic [CNT_W-1:0] C_BLANK = CNT_W'(BLANK);
    assign valid = rst_n & en & (cnt >= C_BLANK);
`else
    logic w_unused;
    assign w_unused = (^cnt) ^ (BLANK == 0);
    assign valid    = rst_n & en;
`endif

endmodule

`default_nettype wire

// File: tb/tb_digit_scan.sv
// ============================================================================
// Module      : tb_digit_scan
// Description : Self-checking bench for digit_scan (DIV=4, BLANK=1).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_digit_scan;

    localparam int DIV   = 4;
    localparam int BLANK = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic [15:0] wdata = '0;
    logic [1:0]  code;
    logic [3:0]  digit;
    logic        valid;
    logic        frame;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state (integers, updated per clock from the input rules)
    int          m_cnt = 0;
    int          m_code = 0;
    logic [15:0] m_active = '0;
    logic [15:0] m_pending = '0;
    bit          m_pend = 0;
    bit          m_frame = 0;

    digit_scan #(.DIV(DIV), .BLANK(BLANK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .load  (load),
        .wdata (wdata),
        .code  (code),
        .digit (digit),
        .valid (valid),
        .frame (frame)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_loop();
        bit tick, wrap;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_cnt = 0; m_code = 0; m_active = '0; m_pending = '0;
                m_pend = 0; m_frame = 0;
            end else begin
                tick = en && (m_cnt == DIV - 1);
                wrap = tick && (m_code == 3);
                if (wrap) m_active = load ? wdata : (m_pend ? m_pending : m_active);
                m_frame = wrap;
                m_pend  = wrap ? 1'b0 : (load ? 1'b1 : m_pend);
                if (load) m_pending = wdata;
                if (en)   m_cnt  = (m_cnt + 1) % DIV;
                if (tick) m_code = (m_code + 1) % 4;
            end
        end
    endtask

    task automatic compare_loop();
        bit exp_valid;
        forever begin
            @(negedge clk);
`ifdef SCAN_BLANK_EN
            exp_valid = rst_n && en && (m_cnt >= BLANK);
`else
            exp_valid = rst_n && en;
`endif
            chk("model_code",  32'(code),  32'(m_code));
            chk("model_digit", 32'(digit), 32'((m_active >> (4 * m_code)) & 16'hF));
            chk("model_valid", 32'(valid), 32'(exp_valid));
            chk("model_frame", 32'(frame), 32'(m_frame && en));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_code(input logic [1:0] v);
        step();
        for (int n = 0; n < 40 && code !== v; n++) step();
        chk("wait_code", 32'(code), 32'(v));
    endtask

    initial begin
        fork
            model_loop();
            compare_loop();
        join_none

        // Reset state
        repeat (3) step();
        chk("rst_code",  32'(code),  0);
        chk("rst_digit", 32'(digit), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_frame", 32'(frame), 0);

        // Code sequence with 4-cycle slots and a one-cycle frame pulse
        rst_n = 1'b1;
        en    = 1'b1;
        repeat (4) step();
        chk("seq_code_after4", 32'(code), 1);
        repeat (12) step();
        chk("seq_code_wrap",  32'(code),  0);
        chk("seq_frame_wrap", 32'(frame), 1);
        step();
        chk("seq_frame_once", 32'(frame), 0);

        // Load mid-frame shows nothing until the wrap
        wait_code(2'd1);
`ifdef SCAN_BLANK_EN
        chk("valid_slot_start", 32'(valid), 0);
`else
        chk("valid_slot_start", 32'(valid), 1);
`endif
        step();
        load = 1'b1; wdata = 16'h4321;
        step();
        load = 1'b0;
        chk("l4321_before_wrap", 32'(digit), 0);
        wait_code(2'd0); chk("l4321_s0", 32'(digit), 1);
        wait_code(2'd1); chk("l4321_s1", 32'(digit), 2);
        wait_code(2'd2); chk("l4321_s2", 32'(digit), 3);
        wait_code(2'd3); chk("l4321_s3", 32'(digit), 4);

        // Two loads in one frame: last one wins
        wait_code(2'd1);
        load = 1'b1; wdata = 16'hAAAA;
        step();
        wdata = 16'h5555;
        step();
        load = 1'b0;
        chk("l5555_before_wrap", 32'(digit), 2);
        wait_code(2'd0); chk("l5555_s0", 32'(digit), 5);
        wait_code(2'd3); chk("l5555_s3", 32'(digit), 5);

        // Load exactly on the wrap cycle (code=3, cnt=3)
        repeat (3) step();
        load = 1'b1; wdata = 16'hBEEF;
        step();
        load = 1'b0;
        chk("lbeef_code",  32'(code),  0);
        chk("lbeef_digit", 32'(digit), 32'hF);
        chk("lbeef_pend",  32'(dut.pend_q), 0);

        // Freeze at code=2, cnt=1 for 10 cycles, loading meanwhile
        wait_code(2'd2);
        step();
        en = 1'b0; load = 1'b1; wdata = 16'h1234;
        step();
        load = 1'b0;
        repeat (9) step();
        chk("frz_code",  32'(code),  2);
        chk("frz_valid", 32'(valid), 0);
        chk("frz_frame", 32'(frame), 0);
        chk("frz_digit", 32'(digit), 32'hE);
        en = 1'b1;
        repeat (2) step();
        chk("resume_code_hold", 32'(code), 2);
        step();
        chk("resume_code_adv", 32'(code), 3);
        wait_code(2'd0); chk("l1234_s0", 32'(digit), 4);

        // Reset mid-slot discards a pending load
        wait_code(2'd1);
        load = 1'b1; wdata = 16'h9999;
        step();
        load = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        chk("arst_code",  32'(code),  0);
        chk("arst_digit", 32'(digit), 0);
        chk("arst_valid", 32'(valid), 0);
        chk("arst_frame", 32'(frame), 0);
        repeat (2) step();
        rst_n = 1'b1;
        wait_code(2'd3);
        wait_code(2'd0);
        chk("post_rst_digit", 32'(digit), 0);
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
